vending_dispense: RTL and testbench

Downstream stage of the vending controller FSM. Consumes the one-cycle sale pulse and 3-bit change amount (in nickels), drives the soda vend motor for a fixed time, then pays change coin by coin through a req/ack handshake with the coin ejector. A one-entry pending slot absorbs a second sale that arrives while a dispense is in progress.

---
 rtl/vending_pkg.sv | 36 +++
 rtl/vend_motor_timer.sv | 47 ++++
 rtl/vending_dispense.sv | 148 ++++++++++++++
 tb/tb_vending_dispense.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vending_pkg.sv
// ============================================================================
// Module      : vending_pkg
// Description : Shared constants, state encoding and change clamp helper for
//               the vending dispense stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package vending_pkg;

  // Change is carried in nickels on a 3-bit bus.
  localparam int CHANGE_W       = 3;
  localparam int DEF_MAX_CHANGE = 4;

  // Value of each coin type, in nickels.
  localparam logic [CHANGE_W-1:0] NICKEL_VAL = 3'd1;
  localparam logic [CHANGE_W-1:0] DIME_VAL   = 3'd2;

  // Dispense FSM state encoding.
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_MOTOR = 2'd1;
  localparam state_t ST_PAY   = 2'd2;
  localparam state_t ST_GAP   = 2'd3;

  // Saturate an incoming change amount to the largest legal value.
  function automatic logic [CHANGE_W-1:0] clamp_change(
    input logic [CHANGE_W-1:0] raw,
    input logic [CHANGE_W-1:0] max_val
  );
    return (raw > max_val) ? max_val : raw;
  endfunction

endpackage

`default_nettype wire

// File: rtl/vend_motor_timer.sv
// ============================================================================
// Module      : vend_motor_timer
// Description : Loadable down-counter that times the vend motor. A load
//               starts a run of MOTOR_CYCLES cycles; done marks the last one.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vend_motor_timer #(
  parameter int MOTOR_CYCLES = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic busy,
  output logic done
);

  localparam int               CNT_W    = $clog2(MOTOR_CYCLES) + 1;
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(MOTOR_CYCLES - 1);

  logic [CNT_W-1:0] count;
  logic             running;

  // Count down from MOTOR_CYCLES-1 to 0, then stop until the next load.
  always_ff @(posedge clk) begin
    if (rst) begin
      count   <= '0;
      running <= 1'b0;
    end else if (load) begin
      count   <= LOAD_VAL;
      running <= 1'b1;
    end else if (running) begin
      if (count == '0) begin
        running <= 1'b0;
      end else begin
        count <= count - 1'b1;
      end
    end
  end

  assign busy = running;
  assign done = running && (count == '0);

endmodule

`default_nettype wire

// File: rtl/vending_dispense.sv
// ============================================================================
// Module      : vending_dispense
// Description : Dispense stage of the vending controller. Runs the vend motor
//               for a fixed time per sale, then pays change one coin at a
//               time over a req/ack handshake. A one-entry pending slot holds
//               a sale that arrives while a dispense is in progress.
//               Build option VEND_DIME_CHANGE_EN: pay with dimes while at
//               least two nickels are owed; otherwise every coin is a nickel.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vending_dispense
  import vending_pkg::*;
#(
  parameter int MOTOR_CYCLES = 8,
  parameter int MAX_CHANGE   = DEF_MAX_CHANGE
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                soda_i,
  input  logic [CHANGE_W-1:0] change_i,
  input  logic                coin_ack_i,
  output logic                motor_o,
  output logic                coin_req_o,
  output logic                coin_dime_o,
  output logic                busy_o,
  output logic                ovf_o
);

  localparam logic [CHANGE_W-1:0] MAX_CHG = CHANGE_W'(MAX_CHANGE);

  state_t              state;
  logic [CHANGE_W-1:0] remaining;
  logic [CHANGE_W-1:0] pend_change;
  logic                pend_valid;
  logic                ovf;

  logic [CHANGE_W-1:0] sale_change;
  logic [CHANGE_W-1:0] coin_val;
  logic [CHANGE_W-1:0] remaining_after;
  logic                take_pending;
  logic                take_sale;
  logic                load_motor;
  logic                sale_to_slot;
  logic                sale_dropped;
  logic                coin_dime;
  logic                motor_busy;
  logic                motor_done;

  assign sale_change  = clamp_change(change_i, MAX_CHG);

  // IDLE prefers the pending slot; a live sale is taken only if it is empty.
  assign take_pending = (state == ST_IDLE) && pend_valid;
  assign take_sale    = (state == ST_IDLE) && !pend_valid && soda_i;
  assign load_motor   = take_pending || take_sale;

  // A sale not taken directly goes to the slot; a slot being consumed this
  // cycle counts as free, so only a truly occupied slot drops the sale.
  assign sale_to_slot = soda_i && !take_sale && (!pend_valid || take_pending);
  assign sale_dropped = soda_i && !take_sale && pend_valid && !take_pending;

`ifdef VEND_DIME_CHANGE_EN
  assign coin_dime = (remaining >= DIME_VAL);
`else
  assign coin_dime = 1'b0;
`endif

  assign coin_val        = coin_dime ? DIME_VAL : NICKEL_VAL;
  // Only evaluated in PAY, where remaining is always at least coin_val.
  assign remaining_after = remaining - coin_val;

  vend_motor_timer #(
    .MOTOR_CYCLES (MOTOR_CYCLES)
  ) u_motor_timer (
    .clk  (clk_i),
    .rst  (rst_i),
    .load (load_motor),
    .busy (motor_busy),
    .done (motor_done)
  );

  // Pending-slot bookkeeping and the sticky overflow flag.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pend_valid  <= 1'b0;
      pend_change <= '0;
      ovf         <= 1'b0;
    end else begin
      if (take_pending) begin
        pend_valid <= 1'b0;
      end
      if (sale_to_slot) begin
        pend_valid  <= 1'b1;
        pend_change <= sale_change;
      end
      if (sale_dropped) begin
        ovf <= 1'b1;
      end
    end
  end

  // Dispense FSM: motor run, then one coin per PAY with a GAP between coins.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= ST_IDLE;
      remaining <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (take_pending) begin
            remaining <= pend_change;
            state     <= ST_MOTOR;
          end else if (take_sale) begin
            remaining <= sale_change;
            state     <= ST_MOTOR;
          end
        end
        ST_MOTOR: begin
          if (motor_done) begin
            state <= (remaining != '0) ? ST_PAY : ST_IDLE;
          end
        end
        ST_PAY: begin
          if (coin_ack_i) begin
            remaining <= remaining_after;
            state     <= (remaining_after == '0) ? ST_IDLE : ST_GAP;
          end
        end
        ST_GAP: begin
          state <= ST_PAY;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign motor_o     = (state == ST_MOTOR) && motor_busy;
  assign coin_req_o  = (state == ST_PAY);
  assign coin_dime_o = (state == ST_PAY) && coin_dime;
  assign busy_o      = (state != ST_IDLE);
  assign ovf_o       = ovf;

endmodule

`default_nettype wire

// File: tb/tb_vending_dispense.sv
// ============================================================================
// Module      : tb_vending_dispense
// Description : Directed self-checking bench for vending_dispense. Expected
//               values follow the build option VEND_DIME_CHANGE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vending_dispense;

`ifdef VEND_DIME_CHANGE_EN
  localparam bit DIME = 1'b1;
`else
  localparam bit DIME = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       soda = 1'b0;
  logic [2:0] change = 3'd0;
  logic       coin_ack_i = 1'b0;
  logic       motor_o, coin_req_o, coin_dime_o, busy_o, ovf_o;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

  vending_dispense dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .soda_i      (soda),
    .change_i    (change),
    .coin_ack_i  (coin_ack_i),
    .motor_o     (motor_o),
    .coin_req_o  (coin_req_o),
    .coin_dime_o (coin_dime_o),
    .busy_o      (busy_o),
    .ovf_o       (ovf_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Plays the coin ejector until the FSM reaches IDLE. ack_delay < 0 holds
  // ack high throughout; otherwise ack comes ack_delay cycles after req rises.
  task automatic run_pay(input int ack_delay, output int nreq, output int ndime,
                         output int badgap, output int rise0, output int rise1,
                         output int rise2, output bit timeout);
    int  wait_cnt;
    int  low_run;
    bit  was_req;
    nreq = 0; ndime = 0; badgap = 0; rise0 = -1; rise1 = -1; rise2 = -1;
    timeout = 1'b1; wait_cnt = 0; low_run = 0; was_req = 1'b0;
    for (int k = 0; k < 300; k++) begin
      if (coin_req_o) begin
        if (!was_req) begin
          if (nreq == 0) rise0 = cyc;
          else if (nreq == 1) rise1 = cyc;
          else if (nreq == 2) rise2 = cyc;
          if (nreq > 0 && low_run != 1) badgap++;
          nreq++;
          if (coin_dime_o) ndime++;
          wait_cnt = 0;
        end
        coin_ack_i = (ack_delay < 0) || (wait_cnt == ack_delay);
        wait_cnt++;
        was_req = 1'b1;
      end else begin
        coin_ack_i = (ack_delay < 0);
        low_run = was_req ? 1 : low_run + 1;
        was_req = 1'b0;
        if (!busy_o) begin
          timeout = 1'b0;
          break;
        end
      end
      step();
    end
    coin_ack_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    n_checks++;
    if ({motor_o, coin_req_o, coin_dime_o, busy_o, ovf_o} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: actual %b required 00000",
               {motor_o, coin_req_o, coin_dime_o, busy_o, ovf_o});
    end
    step();
    n_checks++;
    if (busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle_hold: busy actual %b required 0", busy_o);
    end
  endtask

  task automatic test_no_change();
    int bad = 0;
    soda = 1'b1; change = 3'd0;
    step();
    soda = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (motor_o !== 1'b1 || busy_o !== 1'b1 || coin_req_o !== 1'b0) bad++;
      step();
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL no_change_motor_window: bad cycles actual %0d required 0", bad);
    end
    n_checks++;
    if ({motor_o, busy_o, coin_req_o} !== 3'b000) begin
      n_fail++;
      $display("FAIL no_change_end: motor/busy/req actual %b required 000",
               {motor_o, busy_o, coin_req_o});
    end
  endtask

  task automatic test_change4();
    int t, nreq, ndime, badgap, r0, r1, r2;
    bit to;
    t = cyc;
    soda = 1'b1; change = 3'd4;
    step();
    soda = 1'b0;
    run_pay(2, nreq, ndime, badgap, r0, r1, r2, to);
    n_checks++;
    if (to !== 1'b0) begin n_fail++; $display("FAIL change4_timeout: actual %0d required 0", to); end
    n_checks++;
    if (nreq != (DIME ? 2 : 4)) begin
      n_fail++; $display("FAIL change4_requests: actual %0d required %0d", nreq, DIME ? 2 : 4);
    end
    n_checks++;
    if (ndime != (DIME ? 2 : 0)) begin
      n_fail++; $display("FAIL change4_dimes: actual %0d required %0d", ndime, DIME ? 2 : 0);
    end
    n_checks++;
    if (badgap != 0) begin n_fail++; $display("FAIL change4_gap: bad gaps actual %0d required 0", badgap); end
    n_checks++;
    if (r0 != t + 9 || r1 != t + 13) begin
      n_fail++;
      $display("FAIL change4_req_timing: actual %0d,%0d required %0d,%0d", r0 - t, r1 - t, 9, 13);
    end
    n_checks++;
    if (cyc != t + (DIME ? 16 : 24)) begin
      n_fail++; $display("FAIL change4_idle_cycle: actual %0d required %0d", cyc - t, DIME ? 16 : 24);
    end
  endtask

  task automatic test_change3_ack_high();
    int t, nreq, ndime, badgap, r0, r1, r2;
    bit to;
    coin_ack_i = 1'b1;
    t = cyc;
    soda = 1'b1; change = 3'd3;
    step();
    soda = 1'b0;
    run_pay(-1, nreq, ndime, badgap, r0, r1, r2, to);
    n_checks++;
    if (to !== 1'b0) begin n_fail++; $display("FAIL change3_timeout: actual %0d required 0", to); end
    n_checks++;
    if (nreq != (DIME ? 2 : 3) || ndime != (DIME ? 1 : 0)) begin
      n_fail++;
      $display("FAIL change3_coins: req/dime actual %0d/%0d required %0d/%0d",
               nreq, ndime, DIME ? 2 : 3, DIME ? 1 : 0);
    end
    n_checks++;
    if (r0 != t + 9 || r1 != t + 11) begin
      n_fail++; $display("FAIL change3_req_timing: actual %0d,%0d required 9,11", r0 - t, r1 - t);
    end
    n_checks++;
    if (r2 != (DIME ? -1 : t + 13)) begin
      n_fail++; $display("FAIL change3_third_req: actual %0d required %0d", r2, DIME ? -1 : t + 13);
    end
    n_checks++;
    if (cyc != t + (DIME ? 12 : 14)) begin
      n_fail++; $display("FAIL change3_idle_cycle: actual %0d required %0d", cyc - t, DIME ? 12 : 14);
    end
  endtask

  task automatic test_pending();
    int t, nreq, ndime, badgap, r0, r1, r2, mcount, idle_bad;
    bit to;
    t = cyc;
    soda = 1'b1; change = 3'd0;
    step();
    soda = 1'b0;
    step(); step();
    soda = 1'b1; change = 3'd1;
    step();
    soda = 1'b0;
    run_pay(1, nreq, ndime, badgap, r0, r1, r2, to);
    n_checks++;
    if (to !== 1'b0 || cyc != t + 9 || nreq != 0) begin
      n_fail++;
      $display("FAIL pending_first_done: idle cycle actual %0d required 9 (req %0d, timeout %0d)",
               cyc - t, nreq, to);
    end
    step();
    n_checks++;
    if (motor_o !== 1'b1) begin n_fail++; $display("FAIL pending_restart: motor actual %b required 1", motor_o); end
    mcount = 0;
    for (int k = 0; k < 20; k++) begin
      if (!motor_o) break;
      mcount++;
      step();
    end
    n_checks++;
    if (mcount != 8) begin n_fail++; $display("FAIL pending_motor_len: actual %0d required 8", mcount); end
    run_pay(1, nreq, ndime, badgap, r0, r1, r2, to);
    n_checks++;
    if (to !== 1'b0 || nreq != 1 || ndime != 0 || r0 != t + 18) begin
      n_fail++;
      $display("FAIL pending_coin: req %0d dime %0d at %0d, required 1 0 at 18", nreq, ndime, r0 - t);
    end
    n_checks++;
    if (ovf_o !== 1'b0) begin n_fail++; $display("FAIL pending_no_ovf: actual %b required 0", ovf_o); end

    // Fill the slot, then offer a third sale that must be dropped.
    soda = 1'b1; change = 3'd0;
    step();
    change = 3'd2;
    step();
    change = 3'd3;
    step();
    soda = 1'b0;
    n_checks++;
    if (ovf_o !== 1'b1) begin n_fail++; $display("FAIL overflow_set: actual %b required 1", ovf_o); end
    run_pay(0, nreq, ndime, badgap, r0, r1, r2, to);
    step();
    run_pay(0, nreq, ndime, badgap, r0, r1, r2, to);
    n_checks++;
    if (to !== 1'b0 || nreq != (DIME ? 1 : 2) || ndime != (DIME ? 1 : 0)) begin
      n_fail++;
      $display("FAIL overflow_slot_sale: req/dime actual %0d/%0d required %0d/%0d",
               nreq, ndime, DIME ? 1 : 2, DIME ? 1 : 0);
    end
    idle_bad = 0;
    for (int k = 0; k < 12; k++) begin
      step();
      if (busy_o !== 1'b0 || ovf_o !== 1'b1) idle_bad++;
    end
    n_checks++;
    if (idle_bad != 0) begin
      n_fail++; $display("FAIL overflow_dropped_sale: bad idle cycles actual %0d required 0", idle_bad);
    end
  endtask

  task automatic test_reset_mid_pay();
    int idle_bad;
    soda = 1'b1; change = 3'd2;
    step();
    soda = 1'b0;
    step();
    soda = 1'b1; change = 3'd1;
    step();
    soda = 1'b0;
    for (int k = 0; k < 30; k++) begin
      if (coin_req_o) break;
      step();
    end
    n_checks++;
    if (coin_req_o !== 1'b1) begin n_fail++; $display("FAIL reset_mid_reach_pay: req actual %b required 1", coin_req_o); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_checks++;
    if ({motor_o, coin_req_o, coin_dime_o, busy_o, ovf_o} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_mid_outputs: actual %b required 00000",
               {motor_o, coin_req_o, coin_dime_o, busy_o, ovf_o});
    end
    coin_ack_i = 1'b1;
    step();
    coin_ack_i = 1'b0;
    idle_bad = 0;
    for (int k = 0; k < 12; k++) begin
      if ({motor_o, coin_req_o, busy_o} !== 3'b000) idle_bad++;
      step();
    end
    n_checks++;
    if (idle_bad != 0) begin
      n_fail++; $display("FAIL reset_mid_pending_cleared: bad cycles actual %0d required 0", idle_bad);
    end
  endtask

  task automatic test_clamp();
    int t, nreq, ndime, badgap, r0, r1, r2, bad;
    bit to;
    coin_ack_i = 1'b1;
    step();
    coin_ack_i = 1'b0;
    n_checks++;
    if (busy_o !== 1'b0) begin n_fail++; $display("FAIL clamp_idle_ack: busy actual %b required 0", busy_o); end
    t = cyc;
    soda = 1'b1; change = 3'd7;
    step();
    soda = 1'b0;
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      coin_ack_i = (i % 2 == 1);
      if (motor_o !== 1'b1 || coin_req_o !== 1'b0) bad++;
      step();
    end
    coin_ack_i = 1'b0;
    n_checks++;
    if (bad != 0 || coin_req_o !== 1'b1) begin
      n_fail++;
      $display("FAIL clamp_motor_ack_ignored: bad cycles %0d, req at 9 actual %b required 1", bad, coin_req_o);
    end
    run_pay(1, nreq, ndime, badgap, r0, r1, r2, to);
    n_checks++;
    if (to !== 1'b0 || nreq != (DIME ? 2 : 4) || ndime != (DIME ? 2 : 0) || badgap != 0) begin
      n_fail++;
      $display("FAIL clamp_coins: req/dime actual %0d/%0d required %0d/%0d",
               nreq, ndime, DIME ? 2 : 4, DIME ? 2 : 0);
    end
  endtask

  initial begin
    test_reset();
    test_no_change();
    test_change4();
    test_change3_ack_high();
    test_pending();
    test_reset_mid_pay();
    test_clamp();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
